ram_arbiter: RTL and testbench

- Two-requester arbiter that shares one RAM16K-style single-port memory: combinational read, write on posedge clock when load is high.
- Typical requesters: port 0 is the CPU data side, port 1 is a DMA/screen-refresh engine.
- Round-robin ownership with a bounded burst, so neither port can starve the other.
- Each transfer is a req/ack handshake; read data is returned registered.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_pick.sv | 45 ++++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF    = 14;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  // Burst counter must hold 0..max_burst without wrapping.
  function automatic int unsigned burst_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin owner selection with a bounded burst for the RAM arbiter.
module ram_arbiter_rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned BURST_W   = burst_width(MAX_BURST_DEF)
) (
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic               owner_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  output logic               grant_o,
  output logic               owner_o,
  output logic [BURST_W-1:0] burst_cnt_o
);

  logic req_own;
  logic req_oth;
  logic under_limit;

  assign req_own = owner_i ? req1_i : req0_i;
  assign req_oth = owner_i ? req0_i : req1_i;

  // A zero count means no burst is running (only after reset), so the
  // owner has no claim and a waiting port 0 takes the first tie.
  assign under_limit = (burst_cnt_i != '0) && (burst_cnt_i < BURST_W'(MAX_BURST));

  always_comb begin
    grant_o     = 1'b0;
    owner_o     = owner_i;
    burst_cnt_o = burst_cnt_i;
    if (req_own && under_limit) begin
      grant_o     = 1'b1;
      burst_cnt_o = burst_cnt_i + BURST_W'(1);
    end else if (req_oth) begin
      grant_o     = 1'b1;
      owner_o     = ~owner_i;
      burst_cnt_o = BURST_W'(1);
    end else if (req_own) begin
      grant_o     = 1'b1;
      burst_cnt_o = BURST_W'(1);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM; req/ack handshake per
// transfer, round-robin ownership with bounded bursts, registered read data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              owner,
  output logic              busy
);

  localparam int unsigned BURST_W = burst_width(MAX_BURST);

  arb_state_e         state_q;
  logic               owner_q;
  logic [BURST_W-1:0] burst_q;
  logic               ack0_q;
  logic               ack1_q;
  logic [DATA_W-1:0]  rdata0_q;
  logic [DATA_W-1:0]  rdata1_q;

  logic               grant;
  logic               owner_d;
  logic [BURST_W-1:0] burst_d;
  logic               we_own;

  ram_arbiter_rr_pick #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_rr_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .owner_i     (owner_q),
    .burst_cnt_i (burst_q),
    .grant_o     (grant),
    .owner_o     (owner_d),
    .burst_cnt_o (burst_d)
  );

  assign we_own = owner_q ? we1 : we0;

  // Write strobe decoded from state so an async reset kills it at once.
  assign mem_load    = (state_q == ST_ACC) && we_own;
  assign mem_address = owner_q ? addr1 : addr0;
  assign mem_in      = owner_q ? wdata1 : wdata0;
  assign busy        = (state_q != ST_IDLE);

  assign owner  = owner_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b1;
      burst_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (!we_own) begin
            if (owner_q) rdata1_q <= mem_out;
            else         rdata0_q <= mem_out;
          end
          if (owner_q) ack1_q <= 1'b1;
          else         ack0_q <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM16K model.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, ack0, req1, we1, ack1;
  logic [13:0] addr0, addr1, mem_address;
  logic [15:0] wdata0, wdata1, rdata0, rdata1, mem_in, mem_out;
  logic        mem_load, owner, busy;

  logic [15:0] mem [16384];

  typedef struct packed {
    logic        port;
    logic        chk;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;

  ram_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out),
    .owner(owner), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_out = mem[mem_address];
  always @(posedge clock) if (mem_load) mem[mem_address] <= mem_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic port, input logic chk, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.chk  = chk;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every ack pops the next expected transfer.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_load) wr_cnt++;
      if (ack0 && ack1) begin
        check("ack_both", 32'd1, 32'd0);
      end else if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", {31'd0, ack1}, {31'd0, e.port});
          check("ack_owner", {31'd0, owner}, {31'd0, e.port});
          if (e.chk) check("rdata", {16'd0, (ack1 ? rdata1 : rdata0)}, {16'd0, e.data});
        end
      end
    end
  end

  // Called just after a posedge; returns cycles from request to ack.
  task automatic drive(input logic port, input logic we, input logic [13:0] addr,
                       input logic [15:0] wd, output int lat);
    lat = -1;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (port ? ack1 : ack0) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", {31'd0, port}, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_a, lat_b, max0, max1, w0;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata0", {16'd0, rdata0}, 32'd0);
    check("rst_rdata1", {16'd0, rdata1}, 32'd0);
    check("rst_mem_load", {31'd0, mem_load}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd1);
    reset = 1'b0;

    // Single write then read on port 0
    w0 = wr_cnt;
    push_exp(1'b0, 1'b0, 16'h0000);
    push_exp(1'b0, 1'b1, 16'hBEEF);
    drive(1'b0, 1'b1, 14'h0005, 16'hBEEF, lat);
    check("t1_wr_lat", lat, 32'd2);
    drive(1'b0, 1'b0, 14'h0005, 16'h0000, lat);
    check("t1_rd_lat", lat, 32'd2);
    check("t1_mem5", {16'd0, mem[5]}, 32'h0000BEEF);
    check("t1_load_cycles", wr_cnt - w0, 32'd1);

    // Contention from reset: 4 x port 0, 4 x port 1, repeated
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem[14'h0010 + 14'(i)] <= 16'h1000 + 16'(i);
      mem[14'h0020 + 14'(i)] <= 16'h2000 + 16'(i);
    end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        push_exp(1'(r % 2), 1'b1, ((r % 2) ? 16'h2000 : 16'h1000) + 16'((r / 2) * 4 + k));
    max0 = 0;
    max1 = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(1'b0, 1'b0, 14'h0010 + 14'(i), 16'h0000, lat_a);
          if (lat_a > max0) max0 = lat_a;
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          drive(1'b1, 1'b0, 14'h0020 + 14'(i), 16'h0000, lat_b);
          if (lat_b > max1) max1 = lat_b;
        end
      end
    join
    check("t2_max_wait0", max0, 32'd14);
    check("t2_max_wait1", max1, 32'd14);
    check("t2_sb_drained", sb.size(), 32'd0);

    // Uncontested burst of 10 writes on port 1
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      push_exp(1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 14'(i), 16'hA000 + 16'(i), lat);
      check("t3_lat", lat, 32'd2);
      check("t3_owner", {31'd0, owner}, 32'd1);
    end
    for (int i = 0; i < 10; i++) check("t3_mem", {16'd0, mem[i]}, {16'd0, 16'hA000 + 16'(i)});
    check("t3_load_cycles", wr_cnt - w0, 32'd10);

    // Reset asserted mid-ACC of a port 1 write
    mem[14'h0100] <= 16'h5A5A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 14'h0100; wdata1 = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    check("t4_load_in_acc", {31'd0, mem_load}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_load_drop", {31'd0, mem_load}, 32'd0);
    check("t4_busy_drop", {31'd0, busy}, 32'd0);
    req1 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("t4_mem100", {16'd0, mem[14'h0100]}, 32'h00005A5A);
    check("t4_ack1", {31'd0, ack1}, 32'd0);
    check("t4_rdata0", {16'd0, rdata0}, 32'd0);
    check("t4_rdata1", {16'd0, rdata1}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("t4_idle", {31'd0, busy}, 32'd0);

    // Simultaneous write (port 0) and read (port 1) of address 0
    mem[0] <= 16'hFFFF;
    @(posedge clock); #1;
    w0 = wr_cnt;
    push_exp(1'b0, 1'b0, 16'h0000);
    push_exp(1'b1, 1'b1, 16'h0001);
    fork
      begin
        drive(1'b0, 1'b1, 14'h0000, 16'h0001, lat_a);
        check("t5_lat0", lat_a, 32'd2);
      end
      drive(1'b1, 1'b0, 14'h0000, 16'h0000, lat_b);
      begin
        for (int n = 0; n < 20; n++) begin
          @(negedge clock);
          if (mem_load) break;
        end
        we1 = 1'b1;
        wdata1 = 16'hDEAD;
        #1;
        check("t5_mem_in", {16'd0, mem_in}, 32'h00000001);
        check("t5_mem_addr", {18'd0, mem_address}, 32'd0);
        @(posedge clock); #1;
        check("t5_mem0_after", {16'd0, mem[0]}, 32'h00000001);
        we1 = 1'b0;
        wdata1 = 16'h0000;
      end
    join
    repeat (2) @(posedge clock);
    #1;
    check("t5_mem0_final", {16'd0, mem[0]}, 32'h00000001);
    check("t5_load_cycles", wr_cnt - w0, 32'd1);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
